predictor_trainer: RTL and testbench

- Resolution and training end of the fetch-side branch predictor.
- Takes committed control-flow outcomes from the ROB and maintains a table of 2-bit saturating counters.
- Serves the predictor's direction lookup and raises a one-cycle redirect when the committed direction differs from the direction predicted at fetch.
- Sits between ROB commit and the IF unit. Its query port is read combinationally by the predictor in the same cycle.

---
 rtl/predictor_trainer_pkg.sv | 15 +
 rtl/predictor_trainer_if.sv | 35 +++
 rtl/predictor_trainer_bht_sat_update.sv | 20 ++
 rtl/predictor_trainer.sv | 88 ++++++++
 tb/tb_predictor_trainer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/predictor_trainer_pkg.sv
// Shared types and constants for the branch predictor training path.
package predictor_trainer_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] ins_t;
    typedef logic [1:0]  bht_cnt_t;

    // Table index starts above the 4-byte instruction offset bits.
    localparam int       BHT_IDX_LSB  = 2;

    localparam bht_cnt_t CNT_WEAK_NT  = 2'b01;
    localparam bht_cnt_t CNT_STRONG_T = 2'b11;
    localparam addr_t    INST_LEN     = 32'd4;

endpackage

// File: rtl/predictor_trainer_if.sv
// Commit, redirect, query and statistics bundle between ROB/IF and the trainer.
interface predictor_trainer_if;
    import predictor_trainer_pkg::*;

    addr_t query_pc;
    logic  query_taken;

    logic  commit_valid;
    addr_t commit_pc;
    logic  commit_is_branch;
    logic  commit_taken;
    addr_t commit_target;
    logic  commit_pred_taken;

    logic  redirect_valid;
    addr_t redirect_pc;

    logic [31:0] stat_branch_cnt;
    logic [31:0] stat_miss_cnt;

    modport slave (
        input  query_pc, commit_valid, commit_pc, commit_is_branch,
               commit_taken, commit_target, commit_pred_taken,
        output query_taken, redirect_valid, redirect_pc,
               stat_branch_cnt, stat_miss_cnt
    );

    modport master (
        output query_pc, commit_valid, commit_pc, commit_is_branch,
               commit_taken, commit_target, commit_pred_taken,
        input  query_taken, redirect_valid, redirect_pc,
               stat_branch_cnt, stat_miss_cnt
    );

endinterface

// File: rtl/predictor_trainer_bht_sat_update.sv
// Combinational next-state function for a 2-bit saturating direction counter.
module bht_sat_update
    import predictor_trainer_pkg::*;
(
    input  bht_cnt_t cnt,
    input  logic     taken,
    output bht_cnt_t cnt_next
);

    always_comb begin
        // NOTE: default assignment first so no path through the block leaves cnt_next unassigned (no latch).
        cnt_next = cnt;
        if (taken) begin
            if (cnt != CNT_STRONG_T) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != 2'b00) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/predictor_trainer.sv
// Commit-side branch resolution: trains the 2-bit BHT, raises redirects on
// mispredicts and serves the fetch-time direction lookup with write forwarding.
module predictor_trainer
    import predictor_trainer_pkg::*;
#(
    parameter int       BHT_IDX_WIDTH = 6,
    parameter bht_cnt_t CNT_INIT      = CNT_WEAK_NT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    predictor_trainer_if.slave bus
);

    localparam int BHT_ENTRIES = 1 << BHT_IDX_WIDTH;

    bht_cnt_t bht [BHT_ENTRIES];

    logic                     upd_valid;
    logic [BHT_IDX_WIDTH-1:0] upd_idx;
    logic                     upd_taken;

    logic [BHT_IDX_WIDTH-1:0] query_idx;
    logic [BHT_IDX_WIDTH-1:0] commit_idx;
    bht_cnt_t                 upd_cnt_next;
    bht_cnt_t                 fwd_cnt_next;
    logic                     accept_branch;
    logic                     mispredict;

    assign query_idx     = bus.query_pc[BHT_IDX_LSB +: BHT_IDX_WIDTH];
    assign commit_idx    = bus.commit_pc[BHT_IDX_LSB +: BHT_IDX_WIDTH];
    assign accept_branch = bus.commit_valid && bus.commit_is_branch;
    assign mispredict    = accept_branch && (bus.commit_taken != bus.commit_pred_taken);

    bht_sat_update u_upd_sat (
        .cnt      (bht[upd_idx]),
        .taken    (upd_taken),
        .cnt_next (upd_cnt_next)
    );

    // Same function on the query entry; only used when the query hits the pending update.
    bht_sat_update u_fwd_sat (
        .cnt      (bht[query_idx]),
        .taken    (upd_taken),
        .cnt_next (fwd_cnt_next)
    );

    assign bus.query_taken = (upd_valid && (query_idx == upd_idx)) ? fwd_cnt_next[1]
                                                                   : bht[query_idx][1];

    // Stage 1: capture the training request and resolve the redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_valid           <= 1'b0;
            upd_idx             <= '0;
            upd_taken           <= 1'b0;
            bus.redirect_valid  <= 1'b0;
            bus.redirect_pc     <= '0;
            bus.stat_branch_cnt <= '0;
            bus.stat_miss_cnt   <= '0;
        end else if (rdy) begin
            // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
            upd_valid <= accept_branch;
            if (accept_branch) begin
                upd_idx             <= commit_idx;
                upd_taken           <= bus.commit_taken;
                bus.stat_branch_cnt <= bus.stat_branch_cnt + 32'd1;
            end
            bus.redirect_valid <= mispredict;
            if (mispredict) begin
                bus.redirect_pc   <= bus.commit_taken ? bus.commit_target
                                                      : bus.commit_pc + INST_LEN;
                bus.stat_miss_cnt <= bus.stat_miss_cnt + 32'd1;
            end
        end
    end

    // Stage 2: read-modify-write of the counter one cycle after the commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the table is built from flops rather than RAM because every entry must return to CNT_INIT on async reset.
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_INIT;
        end else if (rdy && upd_valid) begin
            bht[upd_idx] <= upd_cnt_next;
        end
    end

endmodule

// File: tb/tb_predictor_trainer.sv
// Directed bench for predictor_trainer: vector table plus hand-written corner sequences.
module tb_predictor_trainer;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    predictor_trainer_if bus ();

    predictor_trainer #(
        .BHT_IDX_WIDTH (6),
        .CNT_INIT      (2'b01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic drive_commit(input logic [31:0] pc, input logic br, input logic tk,
                                input logic [31:0] tgt, input logic pred);
        bus.commit_valid      = 1'b1;
        bus.commit_pc         = pc;
        bus.commit_is_branch  = br;
        bus.commit_taken      = tk;
        bus.commit_target     = tgt;
        bus.commit_pred_taken = pred;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        is_branch;
        logic        taken;
        logic [31:0] target;
        logic        pred;
        logic        exp_redirect;
        logic [31:0] exp_rpc;
        logic        exp_q;
        logic [31:0] exp_branch;
        logic [31:0] exp_miss;
    } vec_t;

    vec_t vec [13];

    initial begin
        // pc, br, tk, target, pred | redirect, redirect_pc, query_taken, branches, misses
        vec[0]  = '{32'h0000_1000, 1, 1, 32'h0000_2000, 0, 1, 32'h0000_2000, 1, 1,  1};
        vec[1]  = '{32'h0000_1000, 1, 1, 32'h0000_2000, 0, 1, 32'h0000_2000, 1, 2,  2};
        vec[2]  = '{32'h0000_1000, 1, 1, 32'h0000_2000, 1, 0, 32'h0000_2000, 1, 3,  2};
        vec[3]  = '{32'h0000_1040, 1, 0, 32'h0000_5000, 1, 1, 32'h0000_1044, 0, 4,  3};
        vec[4]  = '{32'h0000_1040, 1, 0, 32'h0000_5000, 0, 0, 32'h0000_1044, 0, 5,  3};
        vec[5]  = '{32'h0000_1040, 1, 0, 32'h0000_5000, 0, 0, 32'h0000_1044, 0, 6,  3};
        vec[6]  = '{32'h0000_1040, 1, 0, 32'h0000_5000, 0, 0, 32'h0000_1044, 0, 7,  3};
        vec[7]  = '{32'h0000_1040, 1, 0, 32'h0000_5000, 0, 0, 32'h0000_1044, 0, 8,  3};
        vec[8]  = '{32'h0000_1008, 1, 1, 32'h0000_3008, 0, 1, 32'h0000_3008, 1, 9,  4};
        vec[9]  = '{32'h0000_3004, 0, 1, 32'h0000_4000, 0, 0, 32'h0000_3008, 0, 9,  4};
        vec[10] = '{32'h0000_1040, 1, 1, 32'h0000_1100, 0, 1, 32'h0000_1100, 0, 10, 5};
        vec[11] = '{32'hFFFF_FFFC, 1, 0, 32'h0000_8000, 1, 1, 32'h0000_0000, 0, 11, 6};
        vec[12] = '{32'h0000_1100, 1, 0, 32'h0000_9000, 1, 1, 32'h0000_1104, 1, 12, 7};

        rst = 1'b1;
        rdy = 1'b1;
        bus.query_pc = 32'h0000_1000;
        drive_commit(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        bus.commit_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("reset_query_taken",  bus.query_taken,     0);
        check("reset_redirect",     bus.redirect_valid,  0);
        check("reset_redirect_pc",  bus.redirect_pc,     0);
        check("reset_branch_cnt",   bus.stat_branch_cnt, 0);
        check("reset_miss_cnt",     bus.stat_miss_cnt,   0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive_commit(vec[i].pc, vec[i].is_branch, vec[i].taken, vec[i].target, vec[i].pred);
            bus.query_pc = vec[i].pc;
            @(negedge clk);
            bus.commit_valid = 1'b0;
            #1;
            check($sformatf("v%0d_redirect", i),    bus.redirect_valid,  vec[i].exp_redirect);
            check($sformatf("v%0d_redirect_pc", i), bus.redirect_pc,     vec[i].exp_rpc);
            check($sformatf("v%0d_fwd_query", i),   bus.query_taken,     vec[i].exp_q);
            check($sformatf("v%0d_branch_cnt", i),  bus.stat_branch_cnt, vec[i].exp_branch);
            check($sformatf("v%0d_miss_cnt", i),    bus.stat_miss_cnt,   vec[i].exp_miss);
            @(negedge clk);
            #1;
            check($sformatf("v%0d_redirect_drop", i), bus.redirect_valid, 0);
            check($sformatf("v%0d_table_query", i),   bus.query_taken,    vec[i].exp_q);
        end

        // Back-to-back training of index 16 (counter 01): taken, taken, not-taken -> 10.
        @(negedge clk);
        drive_commit(32'h0000_1040, 1'b1, 1'b1, 32'h0000_7000, 1'b1);
        @(negedge clk);
        drive_commit(32'h0000_1040, 1'b1, 1'b1, 32'h0000_7000, 1'b1);
        @(negedge clk);
        drive_commit(32'h0000_1040, 1'b1, 1'b0, 32'h0000_7000, 1'b1);
        @(negedge clk);
        bus.commit_valid = 1'b0;
        bus.query_pc = 32'h0000_1040;
        #1;
        check("b2b_redirect",    bus.redirect_valid, 1);
        check("b2b_redirect_pc", bus.redirect_pc,    32'h0000_1044);
        @(negedge clk);
        #1;
        check("b2b_both_applied", bus.query_taken,     1);
        check("b2b_branch_cnt",   bus.stat_branch_cnt, 15);
        check("b2b_miss_cnt",     bus.stat_miss_cnt,   8);

        // rdy low: a held commit is ignored.
        @(negedge clk);
        rdy = 1'b0;
        drive_commit(32'h0000_1008, 1'b1, 1'b0, 32'h0000_9000, 1'b1);
        bus.query_pc = 32'h0000_1008;
        repeat (2) @(negedge clk);
        #1;
        check("stall_redirect",    bus.redirect_valid,  0);
        check("stall_redirect_pc", bus.redirect_pc,     32'h0000_1044);
        check("stall_branch_cnt",  bus.stat_branch_cnt, 15);
        check("stall_query",       bus.query_taken,     1);
        rdy = 1'b1;
        @(negedge clk);
        bus.commit_valid = 1'b0;
        rdy = 1'b0;
        #1;
        check("resume_redirect",    bus.redirect_valid, 1);
        check("resume_redirect_pc", bus.redirect_pc,    32'h0000_100C);
        repeat (2) @(negedge clk);
        #1;
        check("stall_redirect_hold", bus.redirect_valid,  1);
        check("stall_miss_cnt",      bus.stat_miss_cnt,   9);
        check("stall_branch_cnt2",   bus.stat_branch_cnt, 16);
        rdy = 1'b1;
        @(negedge clk);
        #1;
        check("release_redirect_drop", bus.redirect_valid, 0);
        check("release_table_query",   bus.query_taken,    0);

        // Async reset while an update to index 0 (counter 10) is pending.
        @(negedge clk);
        drive_commit(32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000, 1'b0);
        bus.query_pc = 32'h0000_1000;
        @(negedge clk);
        bus.commit_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_redirect",    bus.redirect_valid,  0);
        check("async_rst_redirect_pc", bus.redirect_pc,     0);
        check("async_rst_branch_cnt",  bus.stat_branch_cnt, 0);
        check("async_rst_miss_cnt",    bus.stat_miss_cnt,   0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_entry0", bus.query_taken, 0);
        bus.query_pc = 32'h0000_1008;
        #1;
        check("post_rst_entry2", bus.query_taken, 0);

        // Normal operation resumes after reset.
        @(negedge clk);
        drive_commit(32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000, 1'b0);
        bus.query_pc = 32'h0000_1000;
        @(negedge clk);
        bus.commit_valid = 1'b0;
        #1;
        check("post_rst_redirect",    bus.redirect_valid,  1);
        check("post_rst_redirect_pc", bus.redirect_pc,     32'h0000_2000);
        check("post_rst_fwd_query",   bus.query_taken,     1);
        check("post_rst_branch_cnt",  bus.stat_branch_cnt, 1);
        check("post_rst_miss_cnt",    bus.stat_miss_cnt,   1);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
